// File: rtl/vga_sync_decoder_if.sv
// rtl/vga_sync_decoder_if.sv - sync inputs and recovered timing outputs of the VGA sync decoder
interface vga_sync_if #(
    parameter int CW = 11
) ();
    logic          hsync;
    logic          vsync;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          de;
    logic          locked;
    logic          frame_start;
    logic          h_err;
    logic          v_err;
    logic [7:0]    err_cnt;

    // Sync source side: drives the syncs, observes the recovered timing.
    modport master (
        output hsync, vsync,
        input  hcount, vcount, de, locked, frame_start, h_err, v_err, err_cnt
    );

    // Decoder side.
    modport slave (
        input  hsync, vsync,
        output hcount, vcount, de, locked, frame_start, h_err, v_err, err_cnt
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - rebuilds hcount/vcount/de from hsync/vsync and checks timing
module vga_sync_decoder #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_TOTAL  = 1056,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_TOTAL  = 628,
    parameter int CW       = 11
) (
    input  logic     clk,
    input  logic     rst,
    vga_sync_if.slave bus
);

    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

    state_t        state_q, state_d;
    logic          hs_q, hs_qq, vs_q, vs_qq;
    logic [CW-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
    logic          de_q, de_d, locked_q, locked_d, fs_q, fs_d;
    logic          h_err_q, h_err_d, v_err_q, v_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          hs_rise, hs_fall, vs_rise, vs_fall;
    logic [CW-1:0] h_inc, v_inc;

    assign hs_rise = hs_q & ~hs_qq;
    assign hs_fall = ~hs_q & hs_qq;
    assign vs_rise = vs_q & ~vs_qq;
    assign vs_fall = ~vs_q & vs_qq;

    // Free-running position one step ahead; all edge checks compare against it
    // because the edge being examined belongs to the sample the counters are about to show.
    assign h_inc = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
    assign v_inc = (hcount_q != H_LAST) ? vcount_q :
                   (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;

    // Two-stage capture of the incoming syncs for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q  <= 1'b0;
            hs_qq <= 1'b0;
            vs_q  <= 1'b0;
            vs_qq <= 1'b0;
        end else begin
            hs_q  <= bus.hsync;
            hs_qq <= hs_q;
            vs_q  <= bus.vsync;
            vs_qq <= vs_q;
        end
    end

    // Lock FSM, counter reconstruction, violation detection and output decode.
    always_comb begin
        logic h_bad;
        logic v_bad;
        state_d  = state_q;
        hcount_d = h_inc;
        vcount_d = v_inc;
        h_bad    = 1'b0;
        v_bad    = 1'b0;
        case (state_q)
            SEARCH: begin
                hcount_d = '0;
                vcount_d = '0;
                if (hs_rise) begin
                    hcount_d = HS_START;
                    state_d  = HLOCK;
                end
            end
            HLOCK: begin
                if ((hs_rise && h_inc != HS_START) || (hs_fall && h_inc != HS_END))
                    h_bad = 1'b1;
                if (vs_rise) begin
                    if (h_inc != '0) begin
                        v_bad = 1'b1;
                    end else begin
                        vcount_d = VS_START;
                        state_d  = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if ((hs_rise && h_inc != HS_START) || (hs_fall && h_inc != HS_END))
                    h_bad = 1'b1;
                // Edges away from their slot, and levels that are wrong when the slot arrives.
                if (vs_rise && !(h_inc == '0 && v_inc == VS_START))
                    v_bad = 1'b1;
                if (vs_fall && !(h_inc == '0 && v_inc == VS_END))
                    v_bad = 1'b1;
                if (h_inc == '0 && v_inc == VS_START && !vs_q)
                    v_bad = 1'b1;
                if (h_inc == '0 && v_inc == VS_END && vs_q)
                    v_bad = 1'b1;
            end
            default: state_d = SEARCH;
        endcase

        if (h_bad || v_bad) begin
            state_d  = SEARCH;
            hcount_d = '0;
            vcount_d = '0;
        end

        err_cnt_d = err_cnt_q;
        if ((h_bad || v_bad) && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;

        h_err_d  = h_bad;
        v_err_d  = v_bad;
        locked_d = (state_d == LOCKED);
        de_d     = locked_d && (hcount_d < H_ACT) && (vcount_d < V_ACT);
        fs_d     = locked_d && (hcount_d == '0) && (vcount_d == '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEARCH;
            hcount_q  <= '0;
            vcount_q  <= '0;
            de_q      <= 1'b0;
            locked_q  <= 1'b0;
            fs_q      <= 1'b0;
            h_err_q   <= 1'b0;
            v_err_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            de_q      <= de_d;
            locked_q  <= locked_d;
            fs_q      <= fs_d;
            h_err_q   <= h_err_d;
            v_err_q   <= v_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.hcount      = hcount_q;
    assign bus.vcount      = vcount_q;
    assign bus.de          = de_q;
    assign bus.locked      = locked_q;
    assign bus.frame_start = fs_q;
    assign bus.h_err       = h_err_q;
    assign bus.v_err       = v_err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard bench for vga_sync_decoder on a reduced raster
module tb_vga_sync_decoder;

    localparam int HA = 16, HFP = 4, HSW = 8, HT = 36;
    localparam int VA = 12, VFP = 1, VSW = 2, VT = 20;
    localparam int HSS = HA + HFP, HSE = HSS + HSW;
    localparam int VSS = VA + VFP, VSE = VSS + VSW;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        de;
        logic        lk;
        logic        fs;
        logic        he;
        logic        ve;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    vga_sync_if #(.CW(11)) bus ();

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_TOTAL(VT), .CW(11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   gh = 0, gv = 0;
    logic exp_lock = 1'b0;
    logic last_vs  = 1'b0;
    smp_t sb[$];

    function automatic logic nom_hs();
        return (gh >= HSS) && (gh < HSE);
    endfunction

    function automatic logic nom_vs();
        return (gv >= VSS) && (gv < VSE);
    endfunction

    // Drive one generator sample, push its expected decoder view, and return
    // the entry whose outputs are visible now (two samples back) with the DUT view.
    task automatic step(input logic hs, input logic vs, input logic he, input logic ve,
                        output smp_t e, output smp_t o, output bit ok);
        smp_t n;
        @(negedge clk);
        o.h  = bus.hcount;
        o.v  = bus.vcount;
        o.de = bus.de;
        o.lk = bus.locked;
        o.fs = bus.frame_start;
        o.he = bus.h_err;
        o.ve = bus.v_err;
        ok = 1'b0;
        e  = '0;
        if (sb.size() >= 2) begin
            e  = sb.pop_front();
            ok = 1'b1;
        end
        if (!e.lk) begin
            e.h = '0; e.v = '0; o.h = '0; o.v = '0;
        end
        bus.hsync = hs;
        bus.vsync = vs;
        if (he || ve)
            exp_lock = 1'b0;
        else if (vs && !last_vs && gh == 0)
            exp_lock = 1'b1;
        last_vs = vs;
        n.h  = 11'(gh);
        n.v  = 11'(gv);
        n.lk = exp_lock;
        n.de = exp_lock && gh < HA && gv < VA;
        n.fs = exp_lock && gh == 0 && gv == 0;
        n.he = he;
        n.ve = ve;
        sb.push_back(n);
        if (gh == HT - 1) begin
            gh = 0;
            gv = (gv == VT - 1) ? 0 : gv + 1;
        end else begin
            gh = gh + 1;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [34:0] all_o;
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.hsync = ~bus.hsync;
            bus.vsync = (i == 2);
            #1;
            all_o = {bus.hcount, bus.vcount, bus.de, bus.locked, bus.frame_start,
                     bus.h_err, bus.v_err, bus.err_cnt};
            n_tests++;
            if (all_o !== 35'd0) begin
                n_fail++;
                $display("FAIL reset_outputs got=%h want=0", all_o);
            end
        end
        @(negedge clk);
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        rst = 1'b1;
        gh = 0; gv = 0; exp_lock = 1'b0; last_vs = 1'b0;
        sb.delete();
    endtask

    task automatic test_lock();
        smp_t e, o;
        bit   ok;
        int   de_n = 0, fs_n = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            step(nom_hs(), nom_vs(), 1'b0, 1'b0, e, o, ok);
            if (ok) begin
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL lock_stream sample=%0d got=%h want=%h", k - 2, o, e);
                end
                if (k - 2 >= FRAME && k - 2 < 2 * FRAME) begin
                    de_n += int'(o.de);
                    fs_n += int'(o.fs);
                end
            end
        end
        #1;
        n_tests++;
        if (de_n != HA * VA) begin n_fail++; $display("FAIL de_per_frame got=%0d want=%0d", de_n, HA * VA); end
        n_tests++;
        if (fs_n != 1) begin n_fail++; $display("FAIL frame_start_per_frame got=%0d want=1", fs_n); end
        n_tests++;
        if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL lock_err_cnt got=%0d want=0", bus.err_cnt); end
    endtask

    task automatic test_hstretch();
        smp_t e, o;
        bit   ok;
        int   he_n = 0;
        for (int k = 0; k < FRAME; k++) begin
            step(nom_hs() || (gv == 3 && gh == HSE), nom_vs(),
                 (gv == 3 && gh == HSE + 1), 1'b0, e, o, ok);
            if (ok) begin
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL hstretch_stream got=%h want=%h", o, e);
                end
                he_n += int'(o.he);
            end
        end
        #1;
        n_tests++;
        if (he_n != 1) begin n_fail++; $display("FAIL hstretch_pulses got=%0d want=1", he_n); end
        n_tests++;
        if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL hstretch_err_cnt got=%0d want=1", bus.err_cnt); end
        n_tests++;
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL hstretch_relock got=%b want=1", bus.locked); end
    endtask

    task automatic test_vshift();
        smp_t e, o;
        bit   ok;
        int   ve_n = 0;
        logic vs;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (k < FRAME)
                vs = (gv > VSS && gv < VSE) || (gv == VSS && gh >= 5) || (gv == VSE && gh < 5);
            else
                vs = nom_vs();
            step(nom_hs(), vs, 1'b0, (k < FRAME && gv == VSS && gh == 0), e, o, ok);
            if (ok) begin
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL vshift_stream got=%h want=%h", o, e);
                end
                ve_n += int'(o.ve);
            end
        end
        #1;
        n_tests++;
        if (ve_n != 1) begin n_fail++; $display("FAIL vshift_pulses got=%0d want=1", ve_n); end
        n_tests++;
        if (bus.err_cnt !== 8'd2) begin n_fail++; $display("FAIL vshift_err_cnt got=%0d want=2", bus.err_cnt); end
        n_tests++;
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL vshift_relock got=%b want=1", bus.locked); end
    endtask

    task automatic test_simultaneous();
        smp_t e, o;
        bit   ok;
        int   both_n = 0;
        logic hit, win;
        for (int k = 0; k < FRAME; k++) begin
            hit = (gv == 2 && gh == HSS + 3);
            win = (gv == 2 && gh >= HSS + 3 && gh <= HSS + 5);
            step(nom_hs() && !(gv == 2 && gh >= HSS + 3), nom_vs() || win, hit, hit, e, o, ok);
            if (ok) begin
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL simul_stream got=%h want=%h", o, e);
                end
                both_n += int'(o.he && o.ve);
            end
        end
        #1;
        n_tests++;
        if (both_n != 1) begin n_fail++; $display("FAIL simul_both_pulses got=%0d want=1", both_n); end
        n_tests++;
        if (bus.err_cnt !== 8'd3) begin n_fail++; $display("FAIL simul_err_cnt got=%0d want=3", bus.err_cnt); end
    endtask

    task automatic test_saturate();
        smp_t e, o;
        bit   ok;
        int   he_n = 0;
        for (int k = 0; k < 300 * HT; k++) begin
            step(gh >= HSS && gh < HSS + 2, 1'b0, (gh == HSS + 2), 1'b0, e, o, ok);
            if (ok) begin
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL saturate_stream got=%h want=%h", o, e);
                end
                he_n += int'(o.he);
            end
        end
        #1;
        n_tests++;
        if (he_n != 300) begin n_fail++; $display("FAIL saturate_pulses got=%0d want=300", he_n); end
        n_tests++;
        if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL saturate_err_cnt got=%0d want=255", bus.err_cnt); end
    endtask

    task automatic test_midreset();
        smp_t e, o;
        bit   ok;
        logic [34:0] all_o;
        for (int k = 0; k < FRAME + 2 * HT + 10; k++) begin
            step(nom_hs(), nom_vs(), 1'b0, 1'b0, e, o, ok);
            if (ok) begin
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL prereset_stream got=%h want=%h", o, e);
                end
            end
        end
        #1;
        n_tests++;
        if (bus.locked !== 1'b1 || bus.de !== 1'b1) begin
            n_fail++;
            $display("FAIL prereset_locked got=%b%b want=11", bus.locked, bus.de);
        end
        rst = 1'b0;
        #1;
        all_o = {bus.hcount, bus.vcount, bus.de, bus.locked, bus.frame_start,
                 bus.h_err, bus.v_err, bus.err_cnt};
        n_tests++;
        if (all_o !== 35'd0) begin n_fail++; $display("FAIL midreset_async got=%h want=0", all_o); end
        #1;
        rst = 1'b1;
        sb.delete();
        exp_lock = 1'b0;
        last_vs  = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            step(nom_hs(), nom_vs(), 1'b0, 1'b0, e, o, ok);
            if (ok) begin
                n_tests++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL postreset_stream got=%h want=%h", o, e);
                end
            end
        end
        #1;
        n_tests++;
        if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL postreset_relock got=%b want=1", bus.locked); end
        n_tests++;
        if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL postreset_err_cnt got=%0d want=0", bus.err_cnt); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hstretch();
        test_vshift();
        test_simultaneous();
        test_saturate();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receiving end of the VGA timing interface: samples hsync/vsync produced by vga_timing (or any upstream VGA source) and rebuilds hcount/vcount.
- Recovers the active-video enable and reports lock status and timing violations.
- Used as an in-fabric timing checker in front of display sinks and as a self-checking monitor in system benches.
- Default timing is 800x600@60 at 40 MHz, positive sync polarity.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, hsync pulse width (clocks)
H_TOTAL, 1056, clocks per line
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width (lines)
V_TOTAL, 628, lines per frame
CW, 11, counter width

Ports:
clk  in  1  pixel clock, 40 MHz
rst  in  1  asynchronous, active-low reset
hsync  in  1  horizontal sync, active high
vsync  in  1  vertical sync, active high
hcount  out  CW  reconstructed horizontal position
vcount  out  CW  reconstructed vertical position
de  out  1  1 when hcount<H_ACTIVE and vcount<V_ACTIVE, and locked
locked  out  1  timing lock established
frame_start  out  1  one-clock pulse at hcount=0, vcount=0 while locked
h_err  out  1  one-clock pulse on horizontal violation
v_err  out  1  one-clock pulse on vertical violation
err_cnt  out  8  saturating violation count; cleared only by reset

Behaviour:
- Reset (rst=0, async): all outputs 0; state SEARCH; input registers cleared.
- Input path: hsync/vsync pass through two register stages (q, qq). A rise is q&~qq; a fall is ~q&qq. All decisions use these registered samples.
- Latency: outputs describe the sample taken 2 clocks earlier (fixed 2-clock latency).
- Constants: HS_START=H_ACTIVE+H_FP (840), HS_END=HS_START+H_SYNC (968), VS_START=V_ACTIVE+V_FP (601), VS_END=VS_START+V_SYNC (605).
- Free-running counters (HLOCK and LOCKED):
  - hcount wraps H_TOTAL-1 -> 0.
  - On wrap, vcount increments and wraps V_TOTAL-1 -> 0.
- SEARCH:
  - Counters held at 0.
  - On hsync rise: hcount loads HS_START; go to HLOCK.
- HLOCK:
  - Each hsync rise must coincide with hcount==HS_START; each hsync fall with hcount==HS_END. Any mismatch -> h_err pulse, err_cnt+1, return to SEARCH.
  - A vsync rise must coincide with hcount==0; vcount then loads VS_START and the state goes to LOCKED.
  - A vsync rise with hcount!=0 -> v_err pulse, err_cnt+1, go to SEARCH.
- LOCKED:
  - locked=1.
  - hsync edge checks as in HLOCK.
  - vsync rise must coincide with hcount==0 and vcount==VS_START; vsync fall with hcount==0 and vcount==VS_END.
  - A vsync edge at any other position, or a missing expected edge (counter reaches the position, sync level wrong), -> the matching err pulse, err_cnt+1, go to SEARCH.
  - locked and de drop in the same clock the error pulse is raised.
- Simultaneous h and v violation in one clock: both pulses assert; err_cnt increments by 1 only.
- err_cnt saturates at 255.
- frame_start: asserted when the state is LOCKED and the next hcount/vcount are both 0, so the pulse aligns with outputs hcount=0, vcount=0.
- Reset mid-frame: immediate return to reset values; lock must be reacquired from scratch.

Test Plan:
- Drive vga_timing-compliant syncs for 2 frames after reset. Required: locked=1 by the first vsync rise +2 clocks, h_err=v_err=0, err_cnt=0. hcount/vcount equal the generator's counts delayed by 2 clocks.
- Locked stream. Required: frame_start is a single pulse once per 1056*628 clocks; de is high for exactly 800 clocks per line on lines 0..599 and for 480000 clocks per frame.
- Stretch one hsync pulse to 129 clocks. Required: h_err pulse 2 clocks after the late fall, err_cnt=1, locked=0; relock after the next vsync rise.
- Shift vsync rise by 5 clocks in frame 3. Required: v_err pulse, err_cnt increments, locked=0, de=0 from that clock.
- Inject 300 errors. Required: err_cnt holds 255. Simultaneous h+v error increments err_cnt by 1 with both pulses set.
- Assert rst low mid-line while locked. Required: all outputs 0 asynchronously; lock reacquired on the frame after release.
